// File: rtl/ifu_prefetch_pkg.sv
// Shared defaults and helpers for the instruction prefetch unit.
package ifu_prefetch_pkg;

   localparam int          DEF_PC_DW       = 32;
   localparam int          DEF_INST_DW     = 32;
   localparam logic [31:0] DEF_RESET_PC    = 32'h8000_0000;
   localparam int          DEF_INST_BYTES  = 4;
   localparam int          DEF_FETCH_DEPTH = 4;

   // True when value is a non-zero power of two.
   function automatic bit is_pow2(input int value);
      return (value > 32'sd0) && ((value & (value - 32'sd1)) == 32'sd0);
   endfunction

endpackage

// File: rtl/ifu_prefetch_if.sv
// Request/response channel to instruction memory, IDU handshake and redirect.
interface ifu_prefetch_if #(
   parameter int PC_DW   = 32,
   parameter int INST_DW = 32
) ();

   logic               redirect_valid;
   logic [PC_DW-1:0]   redirect_pc;
   logic               imem_req_valid;
   logic               imem_req_ready;
   logic [PC_DW-1:0]   imem_req_addr;
   logic               imem_rsp_valid;
   logic [INST_DW-1:0] imem_rsp_data;
   logic               inst_valid;
   logic               inst_ready;
   logic [PC_DW-1:0]   inst_pc;
   logic [INST_DW-1:0] inst;

   // The fetch unit.
   modport master (
      input  redirect_valid, redirect_pc,
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready,
      input  imem_rsp_valid, imem_rsp_data,
      output inst_valid, inst_pc, inst,
      input  inst_ready
   );

   // Everything around it: redirect source, memory and IDU.
   modport slave (
      output redirect_valid, redirect_pc,
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready,
      output imem_rsp_valid, imem_rsp_data,
      input  inst_valid, inst_pc, inst,
      output inst_ready
   );

endinterface

// File: rtl/Reg.sv
// Generic register primitive with synchronous reset and write enable.
module Reg #(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wen,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   // Hold value, load din when enabled.
   always_ff @(posedge clk) begin
      if (rst) begin
         dout <= RESET_VAL;
      end else if (wen) begin
         dout <= din;
      end
   end

endmodule

// File: rtl/ifu_fetch_queue.sv
// Reservation queue: entries are allocated at request time, filled in order
// by responses and popped in order by the decoder. Flush drops everything.
module ifu_fetch_queue #(
   parameter int PC_DW   = 32,
   parameter int INST_DW = 32,
   parameter int DEPTH   = 4,
   parameter int CNT_W   = $clog2(DEPTH) + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               alloc_en,
   input  logic [PC_DW-1:0]   alloc_pc,
   input  logic               fill_en,
   input  logic [INST_DW-1:0] fill_data,
   input  logic               pop_en,
   output logic               head_filled,
   output logic [PC_DW-1:0]   head_pc,
   output logic [INST_DW-1:0] head_data,
   output logic [CNT_W-1:0]   occupancy,
   output logic [CNT_W-1:0]   unfilled
);

   localparam int             PTR_W   = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

   logic [PC_DW-1:0]   pc_r   [DEPTH];
   logic [INST_DW-1:0] data_r [DEPTH];
   logic [DEPTH-1:0]   filled_r;
   logic [PTR_W-1:0]   alloc_ptr_r;
   logic [PTR_W-1:0]   fill_ptr_r;
   logic [PTR_W-1:0]   head_ptr_r;
   logic [CNT_W-1:0]   occ_r;
   logic [CNT_W-1:0]   unfilled_r;

   // Entry contents and filled flags; alloc, fill and pop never hit the same slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_r[i]   <= {PC_DW{1'b0}};
            data_r[i] <= {INST_DW{1'b0}};
         end
         filled_r <= {DEPTH{1'b0}};
      end else if (flush) begin
         filled_r <= {DEPTH{1'b0}};
      end else begin
         if (alloc_en) begin
            pc_r[alloc_ptr_r]     <= alloc_pc;
            filled_r[alloc_ptr_r] <= 1'b0;
         end
         if (fill_en) begin
            data_r[fill_ptr_r]   <= fill_data;
            filled_r[fill_ptr_r] <= 1'b1;
         end
         if (pop_en) begin
            filled_r[head_ptr_r] <= 1'b0;
         end
      end
   end

   // Wrapping pointers plus occupancy and in-flight counters.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         alloc_ptr_r <= {PTR_W{1'b0}};
         fill_ptr_r  <= {PTR_W{1'b0}};
         head_ptr_r  <= {PTR_W{1'b0}};
         occ_r       <= {CNT_W{1'b0}};
         unfilled_r  <= {CNT_W{1'b0}};
      end else begin
         if (alloc_en) begin
            alloc_ptr_r <= alloc_ptr_r + PTR_ONE;
         end
         if (fill_en) begin
            fill_ptr_r <= fill_ptr_r + PTR_ONE;
         end
         if (pop_en) begin
            head_ptr_r <= head_ptr_r + PTR_ONE;
         end
         occ_r      <= occ_r + CNT_W'(alloc_en) - CNT_W'(pop_en);
         unfilled_r <= unfilled_r + CNT_W'(alloc_en) - CNT_W'(fill_en);
      end
   end

   assign head_filled = filled_r[head_ptr_r];
   assign head_pc     = pc_r[head_ptr_r];
   assign head_data   = data_r[head_ptr_r];
   assign occupancy   = occ_r;
   assign unfilled    = unfilled_r;

endmodule

// File: rtl/ifu_prefetch_checker.sv
// Protocol and configuration assertions for the prefetch unit.
module ifu_prefetch_checker
   import ifu_prefetch_pkg::*;
#(
   parameter int FETCH_DEPTH = 4,
   parameter int CNT_W       = 3
) (
   input logic             clk,
   input logic             rst,
   input logic             redirect_valid,
   input logic [1:0]       redirect_pc_lo,
   input logic             rsp_valid,
   input logic [CNT_W-1:0] unfilled,
   input logic [CNT_W-1:0] drop_cnt
);

   localparam bit DEPTH_IS_POW2 = is_pow2(FETCH_DEPTH);

   // Queue indexing relies on natural pointer wrap.
   a_depth_pow2: assert property (@(posedge clk) DEPTH_IS_POW2);

   // Memory may only answer requests that are still owed.
   a_rsp_owed: assert property (@(posedge clk) disable iff (rst)
      rsp_valid |-> ((unfilled != {CNT_W{1'b0}}) || (drop_cnt != {CNT_W{1'b0}})));

   // Redirect targets are word aligned.
   a_redirect_align: assert property (@(posedge clk) disable iff (rst)
      redirect_valid |-> (redirect_pc_lo == 2'b00));

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction prefetch: issues in-order fetch requests, buffers up to
// FETCH_DEPTH instructions, and discards stale responses after a redirect.
module ifu_prefetch
   import ifu_prefetch_pkg::*;
#(
   parameter int               PC_DW       = DEF_PC_DW,
   parameter int               INST_DW     = DEF_INST_DW,
   parameter logic [PC_DW-1:0] RESET_PC    = PC_DW'(DEF_RESET_PC),
   parameter int               FETCH_DEPTH = DEF_FETCH_DEPTH,
   parameter int               INST_BYTES  = DEF_INST_BYTES
) (
   input logic            clk,
   input logic            rst,
   ifu_prefetch_if.master bus
);

   localparam int               CNT_W     = $clog2(FETCH_DEPTH) + 1;
   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FETCH_DEPTH);
   localparam logic [PC_DW-1:0] PC_STEP   = PC_DW'(INST_BYTES);

   logic [PC_DW-1:0]   fetch_pc_s;
   logic [PC_DW-1:0]   fetch_pc_next_s;
   logic               fetch_pc_wen_s;
   logic [CNT_W-1:0]   drop_cnt_r;
   logic [CNT_W-1:0]   drop_cnt_next_s;
   logic [CNT_W-1:0]   occupancy_s;
   logic [CNT_W-1:0]   unfilled_s;
   logic               req_valid_s;
   logic               req_hs_s;
   logic               fill_en_s;
   logic               pop_en_s;
   logic               inst_valid_s;
   logic               head_filled_s;
   logic [PC_DW-1:0]   head_pc_s;
   logic [INST_DW-1:0] head_data_s;

   // Request gating: no fetch while resetting, redirecting, draining or full.
   always_comb begin
      req_valid_s = 1'b0;
      if (rst || bus.redirect_valid || (drop_cnt_r != CNT_ZERO) || (occupancy_s >= DEPTH_CNT)) begin
         req_valid_s = 1'b0;
      end else begin
         req_valid_s = 1'b1;
      end
   end

   assign req_hs_s     = req_valid_s && bus.imem_req_ready;
   assign fill_en_s    = bus.imem_rsp_valid && (drop_cnt_r == CNT_ZERO) && !bus.redirect_valid;
   assign inst_valid_s = !rst && head_filled_s;
   assign pop_en_s     = inst_valid_s && bus.inst_ready && !bus.redirect_valid;

   assign bus.imem_req_valid = req_valid_s;
   assign bus.imem_req_addr  = fetch_pc_s;
   assign bus.inst_valid     = inst_valid_s;

   // Head instruction to IDU; forced to zero while reset is asserted.
   always_comb begin
      bus.inst_pc = {PC_DW{1'b0}};
      bus.inst    = {INST_DW{1'b0}};
      if (rst) begin
         bus.inst_pc = {PC_DW{1'b0}};
         bus.inst    = {INST_DW{1'b0}};
      end else begin
         bus.inst_pc = head_pc_s;
         bus.inst    = head_data_s;
      end
   end

   // Next fetch address: redirect target wins over sequential advance.
   always_comb begin
      fetch_pc_wen_s  = req_hs_s || bus.redirect_valid;
      fetch_pc_next_s = fetch_pc_s + PC_STEP;
      if (bus.redirect_valid) begin
         fetch_pc_next_s = bus.redirect_pc;
      end else begin
         fetch_pc_next_s = fetch_pc_s + PC_STEP;
      end
   end

   Reg #(
      .WIDTH     (PC_DW),
      .RESET_VAL (RESET_PC)
   ) u_fetch_pc (
      .clk  (clk),
      .rst  (rst),
      .wen  (fetch_pc_wen_s),
      .din  (fetch_pc_next_s),
      .dout (fetch_pc_s)
   );

   // Stale-response count: a redirect turns every still-owed response into
   // one to discard, less any response consumed in the redirect cycle.
   always_comb begin
      drop_cnt_next_s = drop_cnt_r;
      if (bus.redirect_valid) begin
         if (drop_cnt_r != CNT_ZERO) begin
            drop_cnt_next_s = unfilled_s + drop_cnt_r - CNT_W'(bus.imem_rsp_valid);
         end else begin
            drop_cnt_next_s = unfilled_s - CNT_W'(bus.imem_rsp_valid);
         end
      end else if (bus.imem_rsp_valid && (drop_cnt_r != CNT_ZERO)) begin
         drop_cnt_next_s = drop_cnt_r - CNT_ONE;
      end else begin
         drop_cnt_next_s = drop_cnt_r;
      end
   end

   // Stale-response counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         drop_cnt_r <= CNT_ZERO;
      end else begin
         drop_cnt_r <= drop_cnt_next_s;
      end
   end

   ifu_fetch_queue #(
      .PC_DW   (PC_DW),
      .INST_DW (INST_DW),
      .DEPTH   (FETCH_DEPTH),
      .CNT_W   (CNT_W)
   ) u_queue (
      .clk         (clk),
      .rst         (rst),
      .flush       (bus.redirect_valid),
      .alloc_en    (req_hs_s),
      .alloc_pc    (fetch_pc_s),
      .fill_en     (fill_en_s),
      .fill_data   (bus.imem_rsp_data),
      .pop_en      (pop_en_s),
      .head_filled (head_filled_s),
      .head_pc     (head_pc_s),
      .head_data   (head_data_s),
      .occupancy   (occupancy_s),
      .unfilled    (unfilled_s)
   );

   ifu_prefetch_checker #(
      .FETCH_DEPTH (FETCH_DEPTH),
      .CNT_W       (CNT_W)
   ) u_checker (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (bus.redirect_valid),
      .redirect_pc_lo (bus.redirect_pc[1:0]),
      .rsp_valid      (bus.imem_rsp_valid),
      .unfilled       (unfilled_s),
      .drop_cnt       (drop_cnt_r)
   );

endmodule

// File: doc/ifu_prefetch.md
Name: ifu_prefetch

Overview:
- Next-generation instruction fetch unit.
- Replaces the combinational, zero-latency memory read with a valid/ready request channel and an in-order response channel.
- Holds up to FETCH_DEPTH fetched or in-flight instructions in a reservation queue, and supports redirect (branch/jump/trap) with flush and discard of stale responses.
- Sits between the PC-redirect logic of EXU/WBU and the instruction memory or bus bridge; feeds IDU through a valid/ready handshake.

Parameters:
- PC_DW, 32, PC/address width.
- INST_DW, 32, instruction width.
- RESET_PC, 32'h8000_0000, fetch address after reset.
- FETCH_DEPTH, 4, queue entries; power of two, >=2.
- INST_BYTES, 4, PC increment per fetch.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- redirect_valid  in  1  flush queue and restart fetch at redirect_pc
- redirect_pc  in  PC_DW  new fetch address; bits [1:0] must be 0
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  PC_DW  fetch address
- imem_rsp_valid  in  1  response valid; responses return in request order, always accepted
- imem_rsp_data  in  INST_DW  fetched instruction
- inst_valid  out  1  head instruction available to IDU
- inst_ready  in  1  IDU consumes head
- inst_pc  out  PC_DW  PC of head instruction
- inst  out  INST_DW  head instruction

Behaviour:
- The interface is fixed: one clock, clk; reset is rst, synchronous and active-high.
- All state updates on posedge clk.
- On rst: fetch_pc=RESET_PC; alloc/fill/head pointers=0; occupancy=0; drop_cnt=0; all filled bits=0. Consequently imem_req_valid=0, inst_valid=0, and inst_pc/inst=0 during the reset cycle.
- Each queue entry holds {pc, data, filled}.
- A request allocates the entry at the alloc pointer, writes pc=fetch_pc, filled=0.
- imem_req_valid = !rst && !redirect_valid && drop_cnt==0 && occupancy<FETCH_DEPTH.
- imem_req_addr = fetch_pc. Held stable while valid && !ready.
- Request handshake (valid&&ready): fetch_pc += INST_BYTES, alloc_ptr++, occupancy++.
- Response with drop_cnt==0: writes data to the entry at fill_ptr, sets filled=1, fill_ptr++.
- Response with drop_cnt!=0: discarded, drop_cnt--.
- inst_valid = filled bit of the head entry; inst_pc/inst come from the head entry, combinationally.
- Pop (inst_valid&&inst_ready): clear filled, head_ptr++, occupancy--.
- Back-to-back: request, fill and pop can all occur in one cycle. Occupancy changes by (req_hs - pop).
- Full: occupancy==FETCH_DEPTH forces imem_req_valid=0. A pop in that cycle frees the slot for the next cycle, not the same cycle.
- Empty or unfilled head: inst_valid=0. A fill to the head is visible the next cycle (one-cycle response-to-IDU latency).
- Pointers wrap modulo FETCH_DEPTH. Occupancy is log2(FETCH_DEPTH)+1 bits.
- Redirect (has priority over every same-cycle event):
  - next fetch_pc=redirect_pc.
  - all pointers and occupancy are zeroed; all filled bits are cleared.
  - drop_cnt = (allocated-but-unfilled entries) - (imem_rsp_valid && drop_cnt==0 ? 1 : 0) + (drop_cnt!=0 ? drop_cnt-imem_rsp_valid : 0).
  - a same-cycle pop is ignored.
  - no request is issued in the redirect cycle, since req_valid=0.
- Fetch resumes once drop_cnt reaches 0. The first new request may therefore be issued the cycle after the last stale response.
- Back-to-back redirects: each one recomputes drop_cnt with the rule above; the last redirect_pc wins.
- fetch_pc wraps naturally at 2^PC_DW.
- Assertions:
  - no imem_rsp_valid when (unfilled+drop_cnt)==0.
  - redirect_pc[1:0]==0.
  - FETCH_DEPTH is a power of two.

Decomposition:
- The shared defines file carries PC_DW, INST_DW, RESET_PC and INST_BYTES; parameters default to these.
- fetch_pc uses the existing Reg primitive, with wen = req handshake || redirect.
- One sub-module, ifu_fetch_queue: parametrised reservation queue with alloc/fill/pop/flush ports and occupancy/unfilled outputs.
- The top level holds fetch_pc, drop_cnt and the request gating.

Test Plan:
- Reset then imem_req_ready=1, 1-cycle response latency, inst_ready=1 → requests to 0x80000000, 0x80000004, …; IDU sees inst_pc in the same order, with one instruction per cycle in steady state.
- inst_ready=0, memory always ready → exactly 4 requests issued (0x80000000–0x8000000C), then imem_req_valid=0. One pop → exactly one new request, to 0x80000010.
- imem_req_ready toggling 0/1 → imem_req_addr is stable while stalled; no address is skipped or duplicated.
- Two requests outstanding, then redirect_pc=0x80001000 → the 2 stale responses are discarded with no inst_valid. The next request goes to 0x80001000 only after drop_cnt=0, and the first inst_pc is 0x80001000.
- Redirect in the same cycle as a response and a pop → the response is counted as dropped, the pop is ignored, and drop_cnt equals the remaining in-flight count.
- rst asserted with 3 entries held and 1 outstanding → the next cycle has inst_valid=0 and drop_cnt=0, and the first request is to 0x80000000.
